account_ram_arbiter: RTL and testbench

ACCOUNT_RAM_ARBITER -- requirements
Module: account_ram_arbiter

---
 rtl/account_ram_arbiter_if.sv | 56 +++++
 rtl/account_ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_account_ram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/account_ram_arbiter_if.sv
// Bus bundle between the two account-RAM requesters, the arbiter and the RAM.
// slave  : arbiter view (request/RAM read data in; grants, read returns, RAM
//          command, owner and lock_err out).
// master : environment view (the opposite directions).
interface account_ram_arbiter_if #(
  parameter int unsigned RAM_DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH     = 4
);
  // ATM state-machine requester
  logic                      fsm_req;
  logic                      fsm_we;
  logic                      fsm_lock;
  logic [ADDR_WIDTH-1:0]     fsm_addr;
  logic [RAM_DATA_WIDTH-1:0] fsm_wdata;
  logic                      fsm_gnt;
  logic                      fsm_rvalid;
  logic [RAM_DATA_WIDTH-1:0] fsm_rdata;
  // card-handler requester
  logic                      card_req;
  logic                      card_we;
  logic                      card_lock;
  logic [ADDR_WIDTH-1:0]     card_addr;
  logic [RAM_DATA_WIDTH-1:0] card_wdata;
  logic                      card_gnt;
  logic                      card_rvalid;
  logic [RAM_DATA_WIDTH-1:0] card_rdata;
  // single-port account RAM, 1-cycle read latency
  logic                      ram_en;
  logic                      ram_we;
  logic [ADDR_WIDTH-1:0]     ram_addr;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata;
  logic [RAM_DATA_WIDTH-1:0] ram_rdata;
  // lock status
  logic [1:0]                owner;
  logic                      lock_err;

  modport slave (
    input  fsm_req, fsm_we, fsm_lock, fsm_addr, fsm_wdata,
    input  card_req, card_we, card_lock, card_addr, card_wdata,
    input  ram_rdata,
    output fsm_gnt, fsm_rvalid, fsm_rdata,
    output card_gnt, card_rvalid, card_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output owner, lock_err
  );

  modport master (
    output fsm_req, fsm_we, fsm_lock, fsm_addr, fsm_wdata,
    output card_req, card_we, card_lock, card_addr, card_wdata,
    output ram_rdata,
    input  fsm_gnt, fsm_rvalid, fsm_rdata,
    input  card_gnt, card_rvalid, card_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  owner, lock_err
  );
endinterface

// File: rtl/account_ram_arbiter.sv
// Two-requester arbiter (ATM FSM, card handler) in front of a single-port
// account RAM. Round-robin on ties, optional lock that reserves the RAM for one
// requester, and an idle timeout that forcibly releases an abandoned lock.
// Ports: clk, rst_n (async active-low), bus (account_ram_arbiter_if.slave):
//   requests in, same-cycle grants and RAM command out, next-cycle read
//   returns, owner (0 none / 1 fsm / 2 card) and lock_err timeout pulse.
module account_ram_arbiter #(
  parameter int unsigned RAM_DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned LOCK_TIMEOUT   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  account_ram_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FSM  = 2'd1,
    OWN_CARD = 2'd2
  } owner_e;

  owner_e                    owner_q;
  logic                      last_card_q;  // 1: card was granted most recently
  logic [CNT_W-1:0]          cnt_q;
  logic                      fsm_rvalid_q;
  logic                      card_rvalid_q;
  logic                      lock_err_q;

  logic                      owner_req_c;
  logic                      timeout_c;
  logic                      fsm_gnt_c;
  logic                      card_gnt_c;
  logic                      ram_en_c;
  logic                      ram_we_c;
  logic [ADDR_WIDTH-1:0]     ram_addr_c;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata_c;

  // Owner's request and timeout decision. The count saturates at
  // LOCK_TIMEOUT; the release is taken in the following cycle only if the owner
  // is still silent, so an owner request arriving then keeps the lock.
  always_comb begin
    owner_req_c = 1'b0;
    case (owner_q)
      OWN_FSM:  owner_req_c = bus.fsm_req;
      OWN_CARD: owner_req_c = bus.card_req;
      default:  owner_req_c = 1'b0;
    endcase
    timeout_c = (owner_q != OWN_NONE) && !owner_req_c &&
                (cnt_q == CNT_W'(LOCK_TIMEOUT));
  end

  // Grant selection: owner only while locked, otherwise round-robin on ties.
  always_comb begin
    fsm_gnt_c  = 1'b0;
    card_gnt_c = 1'b0;
    if (rst_n) begin
      case (owner_q)
        OWN_FSM:  fsm_gnt_c  = bus.fsm_req;
        OWN_CARD: card_gnt_c = bus.card_req;
        default: begin
          if (bus.fsm_req && bus.card_req) begin
            fsm_gnt_c  = last_card_q;
            card_gnt_c = !last_card_q;
          end else begin
            fsm_gnt_c  = bus.fsm_req;
            card_gnt_c = bus.card_req;
          end
        end
      endcase
    end
  end

  // RAM command mux; idle bus is all zeros.
  always_comb begin
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    if (fsm_gnt_c) begin
      ram_en_c    = 1'b1;
      ram_we_c    = bus.fsm_we;
      ram_addr_c  = bus.fsm_addr;
      ram_wdata_c = bus.fsm_wdata;
    end else if (card_gnt_c) begin
      ram_en_c    = 1'b1;
      ram_we_c    = bus.card_we;
      ram_addr_c  = bus.card_addr;
      ram_wdata_c = bus.card_wdata;
    end
  end

  // Lock ownership, round-robin history, idle counter and read-return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q       <= OWN_NONE;
      last_card_q   <= 1'b1;
      cnt_q         <= '0;
      fsm_rvalid_q  <= 1'b0;
      card_rvalid_q <= 1'b0;
      lock_err_q    <= 1'b0;
    end else begin
      fsm_rvalid_q  <= fsm_gnt_c && !bus.fsm_we;
      card_rvalid_q <= card_gnt_c && !bus.card_we;
      lock_err_q    <= timeout_c;

      // A grant (re)sets ownership from its lock bit; only the owner can be
      // granted while locked, so this also covers the unlock case.
      if (fsm_gnt_c) begin
        last_card_q <= 1'b0;
        owner_q     <= bus.fsm_lock ? OWN_FSM : OWN_NONE;
      end else if (card_gnt_c) begin
        last_card_q <= 1'b1;
        owner_q     <= bus.card_lock ? OWN_CARD : OWN_NONE;
      end else if (timeout_c) begin
        owner_q <= OWN_NONE;
      end

      if ((owner_q == OWN_NONE) || owner_req_c || timeout_c) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(LOCK_TIMEOUT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.fsm_gnt     = fsm_gnt_c;
  assign bus.card_gnt    = card_gnt_c;
  assign bus.ram_en      = ram_en_c;
  assign bus.ram_we      = ram_we_c;
  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_wdata   = ram_wdata_c;
  assign bus.fsm_rvalid  = fsm_rvalid_q;
  assign bus.card_rvalid = card_rvalid_q;
  // Read data is the RAM output in the return cycle, zero otherwise.
  assign bus.fsm_rdata   = fsm_rvalid_q  ? bus.ram_rdata : '0;
  assign bus.card_rdata  = card_rvalid_q ? bus.ram_rdata : '0;
  assign bus.owner       = owner_q;
  assign bus.lock_err    = lock_err_q;
endmodule

// File: tb/tb_account_ram_arbiter.sv
// Testbench for account_ram_arbiter: directed scenarios plus randomized
// request traffic, every cycle compared against a behavioural model.
module tb_account_ram_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  account_ram_arbiter_if #(.RAM_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  account_ram_arbiter #(
    .RAM_DATA_WIDTH(DW),
    .ADDR_WIDTH    (AW),
    .LOCK_TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Account RAM: single port, registered read, with a preload port for setup.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] ram_q;
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who holds the RAM, who went last, how long the holder
  // has been silent, and what read data is due this cycle.
  int            m_holder;
  int            m_last;
  int            m_idle;
  int            m_rd_who;
  logic [DW-1:0] m_rd_data;
  bit            m_err;
  logic [DW-1:0] shadow [0:DEPTH-1];
  bit            f_gnt_seen;
  bit            c_gnt_seen;

  task automatic model_cycle();
    int            who;
    bit            to;
    logic          hreq;
    logic          e_we;
    logic          e_lock;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    who  = 0;
    to   = 0;
    hreq = (m_holder == 1) ? bus.fsm_req : (m_holder == 2) ? bus.card_req : 1'b0;
    if (m_holder != 0) begin
      if (hreq) who = m_holder;
      else if (m_idle >= int'(TO)) to = 1;
    end else if (bus.fsm_req && bus.card_req) who = (m_last == 1) ? 2 : 1;
    else if (bus.fsm_req)  who = 1;
    else if (bus.card_req) who = 2;

    e_we = 1'b0; e_lock = 1'b0; e_addr = '0; e_wd = '0;
    if (who == 1) begin
      e_we = bus.fsm_we; e_lock = bus.fsm_lock; e_addr = bus.fsm_addr; e_wd = bus.fsm_wdata;
    end else if (who == 2) begin
      e_we = bus.card_we; e_lock = bus.card_lock; e_addr = bus.card_addr; e_wd = bus.card_wdata;
    end

    check("fsm_gnt",     32'(bus.fsm_gnt),     32'(who == 1));
    check("card_gnt",    32'(bus.card_gnt),    32'(who == 2));
    check("ram_en",      32'(bus.ram_en),      32'(who != 0));
    check("ram_we",      32'(bus.ram_we),      32'(e_we));
    check("ram_addr",    32'(bus.ram_addr),    32'(e_addr));
    check("ram_wdata",   32'(bus.ram_wdata),   32'(e_wd));
    check("fsm_rvalid",  32'(bus.fsm_rvalid),  32'(m_rd_who == 1));
    check("fsm_rdata",   32'(bus.fsm_rdata),   (m_rd_who == 1) ? 32'(m_rd_data) : 32'd0);
    check("card_rvalid", 32'(bus.card_rvalid), 32'(m_rd_who == 2));
    check("card_rdata",  32'(bus.card_rdata),  (m_rd_who == 2) ? 32'(m_rd_data) : 32'd0);
    check("owner",       32'(bus.owner),       32'(m_holder));
    check("lock_err",    32'(bus.lock_err),    32'(m_err));

    m_err    = to;
    m_rd_who = 0;
    if (who != 0) begin
      m_last = who;
      if (e_we) shadow[e_addr] = e_wd;
      else begin
        m_rd_who  = who;
        m_rd_data = shadow[e_addr];
      end
    end
    if (m_holder != 0 && !hreq && !to) m_idle++;
    else m_idle = 0;
    if (who != 0) m_holder = e_lock ? who : 0;
    else if (to)  m_holder = 0;
    f_gnt_seen = (who == 1);
    c_gnt_seen = (who == 2);
  endtask

  // Every cycle: outputs all-zero under reset, otherwise match the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_fsm_gnt",     32'(bus.fsm_gnt),     32'd0);
      check("rst_card_gnt",    32'(bus.card_gnt),    32'd0);
      check("rst_ram_en",      32'(bus.ram_en),      32'd0);
      check("rst_ram_addr",    32'(bus.ram_addr),    32'd0);
      check("rst_fsm_rvalid",  32'(bus.fsm_rvalid),  32'd0);
      check("rst_card_rvalid", 32'(bus.card_rvalid), 32'd0);
      check("rst_card_rdata",  32'(bus.card_rdata),  32'd0);
      check("rst_owner",       32'(bus.owner),       32'd0);
      check("rst_lock_err",    32'(bus.lock_err),    32'd0);
      m_holder = 0; m_last = 2; m_idle = 0; m_rd_who = 0; m_err = 0;
      f_gnt_seen = 0; c_gnt_seen = 0;
    end else begin
      model_cycle();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fsm(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.fsm_req = req; bus.fsm_we = we; bus.fsm_lock = lock;
    bus.fsm_addr = addr; bus.fsm_wdata = wd;
  endtask

  task automatic set_card(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.card_req = req; bus.card_we = we; bus.card_lock = lock;
    bus.card_addr = addr; bus.card_wdata = wd;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    set_fsm(0, 0, 0, '0, '0);
    set_card(0, 0, 0, '0, '0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  bit            f_pend, c_pend;
  logic          f_we, f_lock, c_we, c_lock;
  logic [AW-1:0] f_addr, c_addr;
  logic [DW-1:0] f_wd, c_wd;
  int            pf, pc;

  initial begin
    rst_n  = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    // requests held high during reset must not leak to the outputs
    set_fsm(1, 0, 1, 4'd1, '0);
    set_card(1, 0, 1, 4'd2, '0);
    step();
    for (int i = 0; i < int'(DEPTH); i++) begin
      pre_en   = 1'b1;
      pre_addr = AW'(i);
      pre_data = (i == 3) ? 16'h04D2 : DW'($urandom);
      shadow[i] = pre_data;
      step();
    end
    pre_en = 1'b0;
    set_fsm(0, 0, 0, '0, '0);
    set_card(0, 0, 0, '0, '0);
    step();
    rst_n = 1'b1;

    // single read with 1-cycle latency
    step(); set_fsm(1, 0, 0, 4'd3, '0);
    @(negedge clk);
    check("rd_gnt",  32'(bus.fsm_gnt),  32'd1);
    check("rd_en",   32'(bus.ram_en),   32'd1);
    check("rd_addr", 32'(bus.ram_addr), 32'd3);
    step(); set_fsm(0, 0, 0, '0, '0);
    @(negedge clk);
    check("rd_rvalid", 32'(bus.fsm_rvalid), 32'd1);
    check("rd_rdata",  32'(bus.fsm_rdata),  32'h04D2);

    // tie alternation from reset
    do_reset();
    step(); set_fsm(1, 0, 0, 4'd1, '0); set_card(1, 0, 0, 4'd2, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'({bus.fsm_gnt, bus.card_gnt}), (k % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end
    set_fsm(0, 0, 0, '0, '0); set_card(0, 0, 0, '0, '0);

    // card lock blocks the fsm until the unlocking write
    do_reset();
    step(); set_card(1, 0, 1, 4'd5, '0);
    @(negedge clk); check("lk_card_gnt", 32'(bus.card_gnt), 32'd1);
    step(); set_card(0, 0, 0, '0, '0); set_fsm(1, 0, 0, 4'd7, '0);
    @(negedge clk);
    check("lk_owner2", 32'(bus.owner), 32'd2);
    check("lk_fsm_wait", 32'(bus.fsm_gnt), 32'd0);
    step();
    @(negedge clk); check("lk_fsm_wait", 32'(bus.fsm_gnt), 32'd0);
    step(); set_card(1, 1, 0, 4'd5, 16'hBEEF);
    @(negedge clk);
    check("lk_card_wr", 32'(bus.card_gnt), 32'd1);
    check("lk_fsm_wait", 32'(bus.fsm_gnt), 32'd0);
    step(); set_card(0, 0, 0, '0, '0);
    @(negedge clk);
    check("lk_owner0", 32'(bus.owner), 32'd0);
    check("lk_fsm_gnt", 32'(bus.fsm_gnt), 32'd1);
    step(); set_fsm(0, 0, 0, '0, '0);

    // lock timeout with a card request waiting
    step(); set_fsm(1, 0, 1, 4'd4, '0);
    @(negedge clk); check("to_fsm_gnt", 32'(bus.fsm_gnt), 32'd1);
    step(); set_fsm(0, 0, 0, '0, '0); set_card(1, 0, 0, 4'd9, '0);
    for (int k = 1; k <= int'(TO) + 1; k++) begin
      @(negedge clk);
      check("to_card_wait", 32'(bus.card_gnt), 32'd0);
      check("to_no_err",    32'(bus.lock_err), 32'd0);
      step();
    end
    @(negedge clk);
    check("to_err",       32'(bus.lock_err), 32'd1);
    check("to_owner0",    32'(bus.owner),    32'd0);
    check("to_card_gnt",  32'(bus.card_gnt), 32'd1);
    step(); set_card(0, 0, 0, '0, '0);
    @(negedge clk); check("to_err_pulse", 32'(bus.lock_err), 32'd0);

    // owner returns exactly when the timeout would release
    step(); set_fsm(1, 0, 1, 4'd6, '0);
    @(negedge clk); check("co_gnt", 32'(bus.fsm_gnt), 32'd1);
    step(); set_fsm(0, 0, 0, '0, '0);
    repeat (int'(TO)) step();
    set_fsm(1, 0, 1, 4'd6, '0);
    @(negedge clk);
    check("co_regnt",  32'(bus.fsm_gnt),  32'd1);
    check("co_no_err", 32'(bus.lock_err), 32'd0);
    step(); set_fsm(0, 0, 0, '0, '0);
    @(negedge clk);
    check("co_no_err", 32'(bus.lock_err), 32'd0);
    check("co_owner1", 32'(bus.owner),    32'd1);
    step(); set_fsm(1, 1, 0, 4'd6, 16'h1234);
    step(); set_fsm(0, 0, 0, '0, '0);
    @(negedge clk); check("co_owner0", 32'(bus.owner), 32'd0);

    // simultaneous write and read of the same word
    do_reset();
    step(); set_fsm(1, 1, 0, 4'd2, 16'h0064); set_card(1, 0, 0, 4'd2, '0);
    @(negedge clk);
    check("wr_fsm_first", 32'(bus.fsm_gnt),  32'd1);
    check("wr_card_wait", 32'(bus.card_gnt), 32'd0);
    step(); set_fsm(0, 0, 0, '0, '0);
    @(negedge clk); check("wr_card_gnt", 32'(bus.card_gnt), 32'd1);
    step(); set_card(0, 0, 0, '0, '0);
    @(negedge clk);
    check("wr_card_rvalid", 32'(bus.card_rvalid), 32'd1);
    check("wr_card_rdata",  32'(bus.card_rdata),  32'h0064);

    // reset between a locked read grant and its return
    step(); set_card(1, 0, 1, 4'd8, '0);
    @(negedge clk); check("rs_card_gnt", 32'(bus.card_gnt), 32'd1);
    step(); set_card(0, 0, 0, '0, '0); rst_n = 1'b0;
    @(negedge clk);
    check("rs_no_rvalid", 32'(bus.card_rvalid), 32'd0);
    check("rs_owner0",    32'(bus.owner),       32'd0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("rs_no_err",    32'(bus.lock_err),    32'd0);
    check("rs_no_rvalid", 32'(bus.card_rvalid), 32'd0);
    step(); set_fsm(1, 0, 0, 4'd1, '0); set_card(1, 0, 0, 4'd1, '0);
    @(negedge clk); check("rs_tie_fsm", 32'({bus.fsm_gnt, bus.card_gnt}), 32'd2);
    step(); set_fsm(0, 0, 0, '0, '0);
    step(); set_card(0, 0, 0, '0, '0);

    // randomized traffic with varying request density
    for (int s = 0; s < 4; s++) begin
      do_reset();
      f_pend = 0; c_pend = 0;
      pf = (s == 0) ? 50 : (s == 1) ? 90 : (s == 2) ? 15 : 60;
      pc = (s == 0) ? 50 : (s == 1) ? 90 : (s == 2) ? 60 : 8;
      for (int c = 0; c < 700; c++) begin
        step();
        if (f_pend && f_gnt_seen) f_pend = 0;
        if (c_pend && c_gnt_seen) c_pend = 0;
        if (!f_pend && int'($urandom_range(99)) < pf) begin
          f_pend = 1; f_we = 1'($urandom_range(1)); f_lock = ($urandom_range(99) < 35);
          f_addr = AW'($urandom_range(DEPTH - 1)); f_wd = DW'($urandom);
        end
        if (!c_pend && int'($urandom_range(99)) < pc) begin
          c_pend = 1; c_we = 1'($urandom_range(1)); c_lock = ($urandom_range(99) < 35);
          c_addr = AW'($urandom_range(DEPTH - 1)); c_wd = DW'($urandom);
        end
        set_fsm(f_pend, f_we, f_lock, f_addr, f_wd);
        set_card(c_pend, c_we, c_lock, c_addr, c_wd);
      end
    end
    step();
    set_fsm(0, 0, 0, '0, '0);
    set_card(0, 0, 0, '0, '0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
